// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose:
//   Load/store memory access controller. It accepts one LDR or STR operation
//   per handshake. It then owns the address bus until the memory acknowledges
//   the access or a wait-cycle limit expires. A one-cycle COMPLETE state
//   follows, in which it reports the result: a load-data pulse or a timeout
//   pulse.
//
// Parameters:
//   DATA_W   register-file / memory data width
//   ADDR_W   memory address width (1..DATA_W), low bits of the address operand
//   TIMEOUT  wait cycles without mem_ack before the access is aborted (1..255)
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   op_code, op_valid      operation in (4'b1101 = LDR, 4'b1110 = STR)
//   op_ready               high only while idle; acceptance = op_valid & op_ready
//   r_w_source_1_address   address operand
//   r_source_2_data        store data operand
//   data_bus_in, mem_ack   memory read data and access completion
//   mem_req, add_bus_sel   memory request / address bus ownership (ACCESS only)
//   read_write_toggle      1 = read, 0 = write
//   add_buss_data_access   memory address (holds last value outside ACCESS)
//   data_bus_out           store data (holds last value outside ACCESS)
//   ldr_sel                writeback mux select for a completing LDR
//   LDR_data_out           last successfully loaded word
//   ldr_valid              one-cycle pulse: LDR_data_out was just updated
//   timeout_err            one-cycle pulse: access aborted on timeout
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        op_code,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] r_w_source_1_address,
    input  logic [DATA_W-1:0] r_source_2_data,
    input  logic [DATA_W-1:0] data_bus_in,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              add_bus_sel,
    output logic              read_write_toggle,
    output logic [ADDR_W-1:0] add_buss_data_access,
    output logic [DATA_W-1:0] data_bus_out,
    output logic              ldr_sel,
    output logic [DATA_W-1:0] LDR_data_out,
    output logic              ldr_valid,
    output logic              timeout_err
);

    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCESS   = 2'd1;
    localparam logic [1:0] ST_COMPLETE = 2'd2;

    // The wait counter shows how many ACCESS cycles have already ended
    // without an ack. The cycle that would push it to TIMEOUT is the last
    // cycle that may still be acknowledged.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              is_ldr_q, is_ldr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ldr_data_q, ldr_data_d;

    logic is_mem_op;
    logic accept;

    // Only the low ADDR_W bits of the address operand reach the bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^r_w_source_1_address;

    assign is_mem_op = (op_code == OP_LDR) || (op_code == OP_STR);
    assign accept    = op_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        is_ldr_d   = is_ldr_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ldr_data_d = ldr_data_q;

        case (state_q)
            ST_IDLE: begin
                // A non-memory opcode is accepted but ignored.
                if (accept && is_mem_op) begin
                    state_d    = ST_ACCESS;
                    wait_cnt_d = 8'd0;
                    is_ldr_d   = (op_code == OP_LDR);
                    err_d      = 1'b0;
                    addr_d     = r_w_source_1_address[ADDR_W-1:0];
                    // Store data is only captured for STR. A load therefore
                    // leaves the write bus at its previous value.
                    if (op_code == OP_STR) begin
                        wdata_d = r_source_2_data;
                    end
                end
            end

            ST_ACCESS: begin
                if (mem_ack) begin
                    // An ack wins even on the cycle that would time out.
                    state_d = ST_COMPLETE;
                    err_d   = 1'b0;
                    if (is_ldr_q) begin
                        ldr_data_d = data_bus_in;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_COMPLETE;
                    err_d      = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            ST_COMPLETE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 8'd0;
            is_ldr_q   <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ldr_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            is_ldr_q   <= is_ldr_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ldr_data_q <= ldr_data_d;
        end
    end

    // The bus registers only change when an access is accepted. They
    // therefore show the current access during ACCESS and keep the last
    // driven value at all other times.
    assign op_ready             = (state_q == ST_IDLE);
    assign mem_req              = (state_q == ST_ACCESS);
    assign add_bus_sel          = (state_q == ST_ACCESS);
    assign read_write_toggle    = (state_q == ST_ACCESS) ? is_ldr_q : 1'b1;
    assign add_buss_data_access = addr_q;
    assign data_bus_out         = wdata_q;
    assign LDR_data_out         = ldr_data_q;
    assign ldr_sel              = (state_q == ST_COMPLETE) && is_ldr_q;
    assign ldr_valid            = (state_q == ST_COMPLETE) && is_ldr_q && !err_q;
    assign timeout_err          = (state_q == ST_COMPLETE) && err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam logic [3:0] LDR = 4'b1101;
    localparam logic [3:0] STR = 4'b1110;
    localparam logic [3:0] NOP = 4'b0011;

    logic        clk;
    logic        rst;
    logic [3:0]  op_code;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] r_w_source_1_address;
    logic [31:0] r_source_2_data;
    logic [31:0] data_bus_in;
    logic        mem_ack;
    logic        mem_req;
    logic        add_bus_sel;
    logic        read_write_toggle;
    logic [15:0] add_buss_data_access;
    logic [31:0] data_bus_out;
    logic        ldr_sel;
    logic [31:0] LDR_data_out;
    logic        ldr_valid;
    logic        timeout_err;

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(15)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .op_code              (op_code),
        .op_valid             (op_valid),
        .op_ready             (op_ready),
        .r_w_source_1_address (r_w_source_1_address),
        .r_source_2_data      (r_source_2_data),
        .data_bus_in          (data_bus_in),
        .mem_ack              (mem_ack),
        .mem_req              (mem_req),
        .add_bus_sel          (add_bus_sel),
        .read_write_toggle    (read_write_toggle),
        .add_buss_data_access (add_buss_data_access),
        .data_bus_out         (data_bus_out),
        .ldr_sel              (ldr_sel),
        .LDR_data_out         (LDR_data_out),
        .ldr_valid            (ldr_valid),
        .timeout_err          (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ack_at: 1-based ACCESS cycle on which mem_ack is driven; 0 = never.
    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
        logic [15:0] exp_addr;
        logic        exp_rw;
        int          exp_acc;
        int          exp_lv;
        int          exp_te;
        int          exp_sel;
        logic [31:0] exp_ldr;
    } vec_t;

    vec_t vecs[8];

    task automatic run_op(input vec_t v, input int idx);
        int          acc;
        int          sel_cnt;
        int          lv;
        int          te;
        int          limit;
        bit          done;
        logic [15:0] seen_addr;
        logic        seen_rw;
        logic [31:0] seen_dout;
        string       tag;
        tag = $sformatf("v%0d", idx);
        check({tag, ".op_ready_before"}, 32'(op_ready), 32'd1);
        op_code              = v.op;
        op_valid             = 1'b1;
        r_w_source_1_address = v.addr;
        r_source_2_data      = v.wdata;
        mem_ack              = 1'b0;
        @(posedge clk); #1;
        // Scramble operands: the access in flight must not follow them.
        op_valid             = 1'b0;
        op_code              = 4'b0000;
        r_w_source_1_address = ~v.addr;
        r_source_2_data      = ~v.wdata;
        acc = 0; sel_cnt = 0; lv = 0; te = 0; done = 0;
        seen_addr = '0; seen_rw = 1'b0; seen_dout = '0;
        limit = (v.exp_acc == 0) ? 5 : 40;
        for (int c = 0; c < limit && !done; c++) begin
            if (mem_req) begin
                acc++;
                if (add_bus_sel) sel_cnt++;
                if (acc == 1 || add_buss_data_access != v.exp_addr) seen_addr = add_buss_data_access;
                if (acc == 1 || read_write_toggle != v.exp_rw) seen_rw = read_write_toggle;
                if (acc == 1 || data_bus_out != v.wdata) seen_dout = data_bus_out;
                mem_ack     = (acc == v.ack_at);
                data_bus_in = (acc == v.ack_at) ? v.rdata : (32'h0BAD_0000 | 32'(acc));
            end else begin
                // Outside ACCESS an ack must be ignored; exercise that on the
                // non-memory vector.
                mem_ack = (v.exp_acc == 0);
                if (ldr_valid) lv++;
                if (timeout_err) te++;
                if (ldr_sel) sel_cnt += 100;
                if (op_ready && acc > 0) done = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        mem_ack = 1'b0;
        check({tag, ".access_cycles"}, 32'(acc), 32'(v.exp_acc));
        check({tag, ".ldr_valid_pulses"}, 32'(lv), 32'(v.exp_lv));
        check({tag, ".timeout_pulses"}, 32'(te), 32'(v.exp_te));
        check({tag, ".bus_sel_and_ldr_sel"}, 32'(sel_cnt), 32'(v.exp_acc + 100 * v.exp_sel));
        check({tag, ".LDR_data_out"}, LDR_data_out, v.exp_ldr);
        check({tag, ".op_ready_after"}, 32'(op_ready), 32'd1);
        if (v.exp_acc > 0) begin
            check({tag, ".finished"}, 32'(done), 32'd1);
            check({tag, ".addr_in_access"}, 32'(seen_addr), 32'(v.exp_addr));
            check({tag, ".rw_in_access"}, 32'(seen_rw), 32'(v.exp_rw));
            check({tag, ".addr_held"}, 32'(add_buss_data_access), 32'(v.exp_addr));
            if (v.op == STR) begin
                check({tag, ".dout_in_access"}, seen_dout, v.wdata);
                check({tag, ".dout_held"}, data_bus_out, v.wdata);
            end
        end
        $display("vec %0d op=%b addr=0x%08h acc=%0d lv=%0d te=%0d ldr=0x%08h",
                 idx, v.op, v.addr, acc, lv, te, LDR_data_out);
    endtask

    initial begin
        int   pulses;
        vec_t post_rst;

        //          op   addr          wdata         rdata         ack  exp_addr rw acc lv te sel exp_ldr
        vecs[0] = '{LDR, 32'h0001_00A4, 32'h5555_AAAA, 32'hDEAD_BEEF, 3,  16'h00A4, 1, 3,  1, 0, 1, 32'hDEAD_BEEF};
        vecs[1] = '{STR, 32'h0000_0010, 32'h1234_5678, 32'h1111_1111, 1,  16'h0010, 0, 1,  0, 0, 0, 32'hDEAD_BEEF};
        vecs[2] = '{LDR, 32'hFFFF_1234, 32'h0000_0000, 32'h2222_2222, 0,  16'h1234, 1, 15, 0, 1, 1, 32'hDEAD_BEEF};
        vecs[3] = '{LDR, 32'h0000_BEEF, 32'h0000_0000, 32'hCAFE_F00D, 15, 16'hBEEF, 1, 15, 1, 0, 1, 32'hCAFE_F00D};
        vecs[4] = '{NOP, 32'h0000_7777, 32'h8888_8888, 32'h3333_3333, 1,  16'h0000, 1, 0,  0, 0, 0, 32'hCAFE_F00D};
        vecs[5] = '{STR, 32'hABCD_0000, 32'hA5A5_5A5A, 32'h4444_4444, 14, 16'h0000, 0, 14, 0, 0, 0, 32'hCAFE_F00D};
        vecs[6] = '{STR, 32'h0000_0007, 32'h0000_0001, 32'h5555_5555, 0,  16'h0007, 0, 15, 0, 1, 0, 32'hCAFE_F00D};
        vecs[7] = '{LDR, 32'h0000_8000, 32'hFFFF_FFFF, 32'h0000_0001, 1,  16'h8000, 1, 1,  1, 0, 1, 32'h0000_0001};
        post_rst = '{LDR, 32'h0003_0099, 32'h0000_0000, 32'h600D_F00D, 2, 16'h0099, 1, 2, 1, 0, 1, 32'h600D_F00D};

        rst = 1'b1; op_code = 4'b0000; op_valid = 1'b0; mem_ack = 1'b0;
        r_w_source_1_address = '0; r_source_2_data = '0; data_bus_in = '0;

        // Reset state is visible before any clock edge.
        #2;
        check("rst.op_ready", 32'(op_ready), 32'd1);
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.add_bus_sel", 32'(add_bus_sel), 32'd0);
        check("rst.rw", 32'(read_write_toggle), 32'd1);
        check("rst.ldr_flags", {29'd0, ldr_sel, ldr_valid, timeout_err}, 32'd0);
        check("rst.LDR_data_out", LDR_data_out, 32'd0);
        check("rst.data_bus_out", data_bus_out, 32'd0);
        check("rst.addr", 32'(add_buss_data_access), 32'd0);
        $display("reset state checked");

        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_op(vecs[i], i);

        // Reset in the middle of an access.
        op_code = LDR; op_valid = 1'b1; r_w_source_1_address = 32'h0000_0044;
        @(posedge clk); #1;
        op_valid = 1'b0;
        check("midrst.mem_req_before", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; mem_ack = 1'b1; data_bus_in = 32'h9999_9999;
        #1;
        check("midrst.mem_req", 32'(mem_req), 32'd0);
        check("midrst.add_bus_sel", 32'(add_bus_sel), 32'd0);
        check("midrst.op_ready", 32'(op_ready), 32'd1);
        check("midrst.LDR_data_out", LDR_data_out, 32'd0);
        check("midrst.addr", 32'(add_buss_data_access), 32'd0);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (ldr_valid || timeout_err) pulses++;
        end
        check("midrst.no_pulses", 32'(pulses), 32'd0);
        $display("mid-access reset: pulses=%0d LDR_data_out=0x%08h", pulses, LDR_data_out);
        mem_ack = 1'b0;
        rst = 1'b0;
        // Accepted on the first rising edge after reset release.
        run_op(post_rst, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: width of register-file data and memory data bus.
REQ-002 Parameter ADDR_W, default 16, legal range 1..DATA_W: memory address width; address = r_w_source_1_address[ADDR_W-1:0].
REQ-003 Parameter TIMEOUT, default 15, legal range 1..255: max cycles waiting for mem_ack before abort.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port rst  in  1  reset; asynchronous, active-high.
REQ-006 Port op_code  in  4  instruction opcode; 4'b1101 = LDR, 4'b1110 = STR, all others = non-memory.
REQ-007 Port op_valid  in  1  op_code and operands valid this cycle.
REQ-008 Port op_ready  out  1  controller can accept an operation.
REQ-009 Port r_w_source_1_address  in  DATA_W  address operand.
REQ-010 Port r_source_2_data  in  DATA_W  store data operand.
REQ-011 Port data_bus_in  in  DATA_W  read data from memory.
REQ-012 Port mem_ack  in  1  memory completes the current access.
REQ-013 Port mem_req  out  1  memory access request.
REQ-014 Port add_bus_sel  out  1  address bus owned by this block.
REQ-015 Port read_write_toggle  out  1  1 = read, 0 = write.
REQ-016 Port add_buss_data_access  out  ADDR_W  memory address.
REQ-017 Port data_bus_out  out  DATA_W  write data to memory.
REQ-018 Port ldr_sel  out  1  writeback mux selects LDR_data_out.
REQ-019 Port LDR_data_out  out  DATA_W  loaded data.
REQ-020 Port ldr_valid  out  1  one-cycle pulse: LDR_data_out holds new load data.
REQ-021 Port timeout_err  out  1  one-cycle pulse: access aborted on timeout.

Function
REQ-022 FSM states: IDLE, ACCESS, COMPLETE; op_ready = 1 only in IDLE.
REQ-023 Handshake: an operation is accepted on a rising edge where op_valid=1 and op_ready=1.
REQ-024 Accepted LDR/STR: latch opcode, address[ADDR_W-1:0] and r_source_2_data into internal registers; IDLE -> ACCESS.
REQ-025 Accepted non-memory opcode: no state change, no bus activity, no output pulses.
REQ-026 In ACCESS: mem_req=1, add_bus_sel=1, add_buss_data_access = latched address, read_write_toggle = 1 for LDR and 0 for STR, data_bus_out = latched data for STR.
REQ-027 Operands are sampled only at acceptance; later changes on inputs do not affect the access in progress.
REQ-028 ACCESS with mem_ack=1: for LDR, LDR_data_out <= data_bus_in; go to COMPLETE with success.
REQ-029 Wait counter (8-bit) clears on entry to ACCESS and increments each ACCESS cycle with mem_ack=0; when it reaches TIMEOUT with mem_ack still 0, go to COMPLETE with error.
REQ-030 mem_ack on the same cycle the counter would reach TIMEOUT counts as success; ack wins.
REQ-031 COMPLETE lasts exactly one cycle and then returns to IDLE; in COMPLETE mem_req=0, add_bus_sel=0.
REQ-032 In COMPLETE: ldr_valid=1 only for successful LDR; timeout_err=1 only for timeout; for LDR, ldr_sel=1.
REQ-033 On LDR timeout, LDR_data_out keeps its previous value.
REQ-034 Latency: accept at edge N; mem_req high in cycle N+1; ack sampled at edge M; COMPLETE in cycle M+1; op_ready high again in cycle M+2. Back-to-back minimum is 3 cycles per memory op.
REQ-035 mem_ack outside ACCESS is ignored.
REQ-036 In IDLE: mem_req=0, add_bus_sel=0, read_write_toggle=1, ldr_sel=0, ldr_valid=0, timeout_err=0.
REQ-037 data_bus_out and add_buss_data_access hold their last driven values outside ACCESS.

Reset
REQ-038 While rst=1, the state is IDLE and the wait counter is 0 with no clock required; outputs take their IDLE values and LDR_data_out, data_bus_out and add_buss_data_access are 0.
REQ-039 Reset during ACCESS or COMPLETE aborts the access and produces no ldr_valid or timeout_err pulse.
REQ-040 First acceptance is possible on the first rising edge after rst deasserts.

Verification
REQ-041 LDR addr 0x0001_00A4, ack after 2 wait cycles with data_bus_in=0xDEAD_BEEF -> add_buss_data_access=0x00A4, read_write_toggle=1 during ACCESS; ldr_valid is a single pulse; LDR_data_out=0xDEAD_BEEF.
REQ-042 STR addr 0x10, data 0x1234_5678, ack on the first ACCESS cycle -> mem_req is high for 1 cycle, read_write_toggle=0, data_bus_out=0x1234_5678, no ldr_valid.
REQ-043 LDR with mem_ack held 0, TIMEOUT=15 -> mem_req is high for exactly 15 cycles, then timeout_err is a single pulse and LDR_data_out is unchanged.
REQ-044 Ack arrives on the final counted cycle -> success; no timeout_err.
REQ-045 op_code=4'b0011 with op_valid=1 -> state stays IDLE, mem_req stays 0.
REQ-046 rst asserted mid-ACCESS, then mem_ack=1 -> outputs take IDLE/reset values immediately, and there is no ldr_valid or timeout_err.
